// File: rtl/seq_accumulator.sv
// Burst accumulator: sums a valid/ready operand stream per burst and emits one
// registered result (sum, beat count, sticky carry) per burst.

module ripple_carry_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  carry_out
);

    logic [DATA_WIDTH:0] carry;

    assign carry[0] = carry_in;

    // One full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
        assign sum_out[i]   = a_in[i] ^ b_in[i] ^ carry[i];
        assign carry[i+1]   = (a_in[i] & b_in[i]) | (carry[i] & (a_in[i] ^ b_in[i]));
    end

    assign carry_out = carry[DATA_WIDTH];

endmodule

module seq_accumulator #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned MAX_COUNT  = 16
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  op_valid_in,
    output logic                                  op_ready_out,
    input  logic [DATA_WIDTH-1:0]                 op_data_in,
    input  logic                                  op_last_in,
    output logic                                  res_valid_out,
    input  logic                                  res_ready_in,
    output logic [ACC_WIDTH-1:0]                  res_sum_out,
    output logic [$clog2(MAX_COUNT+1)-1:0]        res_count_out,
    output logic                                  res_overflow_out
);

    localparam int unsigned CW = $clog2(MAX_COUNT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]           state, state_d;
    logic [ACC_WIDTH-1:0] acc, acc_d;
    logic [CW-1:0]        count, count_d;
    logic                 ovf, ovf_d;
    logic                 ready, ready_d;
    logic                 valid, valid_d;

    logic [ACC_WIDTH-1:0] add_a;
    logic [ACC_WIDTH-1:0] add_b;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_carry;
    logic                 accept;
    logic [CW-1:0]        count_inc;
    logic                 closing;

    // A fresh burst starts from zero regardless of any stale accumulator value
    assign add_a = (state == IDLE) ? ACC_WIDTH'(0) : acc;
    assign add_b = ACC_WIDTH'(op_data_in);

    ripple_carry_adder #(
        .DATA_WIDTH (ACC_WIDTH)
    ) u_adder (
        .a_in      (add_a),
        .b_in      (add_b),
        .carry_in  (1'b0),
        .sum_out   (add_sum),
        .carry_out (add_carry)
    );

    assign accept    = op_valid_in & ready;
    assign count_inc = count + CW'(1);
    // count is zero in IDLE, so this also covers MAX_COUNT == 1 on the first beat
    assign closing   = op_last_in | (count_inc == CW'(MAX_COUNT));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            ready <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            count <= count_d;
            ovf   <= ovf_d;
            ready <= ready_d;
            valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        count_d = count;
        ovf_d   = ovf;
        valid_d = valid;

        case (state)
            IDLE: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = 1'b0;
                    if (closing) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = ovf | add_carry;
                    if (closing) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (res_ready_in) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != HOLD);
    end

    assign op_ready_out     = ready;
    assign res_valid_out    = valid;
    assign res_sum_out      = acc;
    assign res_count_out    = count;
    assign res_overflow_out = ovf;

endmodule

// File: doc/seq_accumulator.md
Name: seq_accumulator

Overview:
- Multi-cycle accumulation stage built around the team's ripple_carry_adder.
- Consumes a valid/ready stream of DATA_WIDTH operands, sums each burst into an ACC_WIDTH accumulator, and emits one result per burst with beat count and sticky overflow.
- Sits downstream of operand producers and upstream of result consumers in the datapath.

Parameters:
- DATA_WIDTH, 8, operand width in bits.
- ACC_WIDTH, 16, accumulator and result width in bits; must be >= DATA_WIDTH.
- MAX_COUNT, 16, maximum beats per burst; the burst force-closes at this count. Must be >= 1.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- op_valid_in  input  1  operand valid.
- op_ready_out  output  1  operand ready.
- op_data_in  input  DATA_WIDTH  operand, unsigned.
- op_last_in  input  1  marks the final beat of a burst.
- res_valid_out  output  1  result valid.
- res_ready_in  input  1  result ready.
- res_sum_out  output  ACC_WIDTH  burst sum, modulo 2^ACC_WIDTH.
- res_count_out  output  CW  beats in the burst, where CW = $clog2(MAX_COUNT+1).
- res_overflow_out  output  1  set if any addition in the burst produced a carry out.

Behaviour:
- Reset (async, active-low): state=IDLE; acc=0; count=0; ovf=0; op_ready_out=0 while rst_n_in is low, then 1 after release; res_valid_out=0; res_sum_out=0; res_count_out=0; res_overflow_out=0.
- Adder: one ripple_carry_adder instance, DATA_WIDTH=ACC_WIDTH.
  - a_in = acc; b_in = zero-extended op_data_in; carry_in=0.
  - carry_out is the overflow indicator for that beat.
- Beat accept: op_valid_in & op_ready_out at a rising edge.
- FSM states:
  - IDLE: op_ready_out=1. On accept: acc <= 0 + op (adder a_in is forced to 0); count <= 1; ovf <= 0. Go to ACCUM, or to HOLD if op_last_in=1 or MAX_COUNT=1.
  - ACCUM: op_ready_out=1. On accept: acc <= adder sum; count <= count+1; ovf <= ovf | carry_out. Go to HOLD if op_last_in=1 or count+1==MAX_COUNT. With no accept, hold all state.
  - HOLD: op_ready_out=0; res_valid_out=1. res_sum_out, res_count_out and res_overflow_out are registered and stable while res_valid_out=1. On res_ready_in=1: res_valid_out <= 0, acc/count/ovf <= 0, go to IDLE.
- Latency: res_valid_out asserts on the cycle after the closing beat is accepted.
- Results from different bursts never overlap. A new burst can be accepted the cycle after the result handshake, so throughput is one burst per (beats + 1 + result wait) cycles.
- Wrap-around: the sum wraps modulo 2^ACC_WIDTH. ovf is sticky for the rest of the burst.
- op_valid_in deasserting mid-burst inserts bubbles only; the burst stays open.
- A forced close at MAX_COUNT behaves exactly like op_last_in. A later op_last_in starts a new one-beat burst.
- res_ready_in held high in IDLE or ACCUM has no effect.
- Reset asserted mid-burst or in HOLD: the partial result is discarded, all outputs return to reset values immediately, and no result is emitted.
- No combinational path from op_valid_in or res_ready_in to any output other than through registers. op_ready_out depends only on state.

Test Plan:
- Single burst: ops 3, 5, 7 with last on 7, res_ready_in=1 → res_valid_out one cycle after the 7 is accepted; sum=15, count=3, ovf=0; op_ready_out low for exactly one cycle.
- Overflow/wrap: ACC_WIDTH=8, DATA_WIDTH=8, ops 200, 100 (last) → sum=44, count=2, ovf=1. The next burst, op 1 (last) → sum=1, ovf=0.
- Max count: MAX_COUNT=4, five ops of 1 with no last → first result sum=4, count=4. After the handshake, the fifth op is accepted; it begins a new burst and no result is emitted until last.
- Backpressure: res_ready_in=0 for 10 cycles after the result → outputs stable, op_ready_out=0, and an operand presented in HOLD is not consumed. Release → handshake, and that operand is accepted in IDLE on the following cycle.
- Bubbles: op_valid_in toggled 1,0,0,1,0,1(last) with data 2, x, x, 4, x, 6 → sum=12, count=3.
- Reset mid-burst: accept 9, 9, then pull rst_n_in low asynchronously → all outputs 0 immediately. After release, burst 1 (last) → sum=1, count=1.
